// File: rtl/reset_sequencer.sv
// reset_sequencer: arbitrates reset requests and releases the domain resets in stage order, recording a sticky cause.
module reset_sequencer #(
    parameter int NUM_SRC     = 4,
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
) (
    input  logic                  sysclk,
    input  logic                  reset_n,
    input  logic [NUM_SRC-1:0]    src_req,
    output logic [NUM_SRC-1:0]    src_ack,
    input  logic                  hold_ext,
    output logic [NUM_STAGES-1:0] stage_reset,
    output logic                  busy,
    output logic [NUM_SRC:0]      cause,
    input  logic                  cause_clr
);
    localparam int MAXC = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW = $clog2(MAXC) + 1;
    localparam logic [NUM_STAGES-1:0] LAST_STAGE = NUM_STAGES'(1) << (NUM_STAGES - 1);

    typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_IDLE} state_t;

    state_t                r_state, w_nxt_state;
    logic [CW-1:0]         r_cnt, w_nxt_cnt, w_cnt_inc;
    logic [NUM_STAGES-1:0] r_sr, w_nxt_sr;
    logic                  r_busy, w_nxt_busy;
    logic [NUM_SRC-1:0]    r_ack, r_req_d, w_edge;
    logic [NUM_SRC:0]      r_cause, w_nxt_cause;
    logic                  r_hold_s1, r_hold_s2;

    assign w_edge      = src_req & ~r_req_d;
    assign w_cnt_inc   = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    assign w_nxt_cause = ((cause_clr && r_state == S_IDLE) ? '0 : r_cause) | {w_edge, 1'b0};

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = w_cnt_inc;
        w_nxt_sr    = r_sr;
        w_nxt_busy  = r_busy;
        if (|w_edge || r_hold_s2) begin
            w_nxt_state = S_HOLD;
            w_nxt_cnt   = '0;
            w_nxt_sr    = '1;
            w_nxt_busy  = 1'b1;
        end else begin
            case (r_state)
                S_HOLD: if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
                    w_nxt_sr    = r_sr << 1;
                    w_nxt_cnt   = '0;
                    w_nxt_state = (NUM_STAGES == 1) ? S_IDLE : S_RELEASE;
                    w_nxt_busy  = (NUM_STAGES != 1);
                end
                S_RELEASE: if (r_cnt == CW'(STAGE_GAP - 1)) begin
                    // stages drop LSB first, so shifting left preserves release order
                    w_nxt_sr    = r_sr << 1;
                    w_nxt_cnt   = '0;
                    w_nxt_state = (r_sr == LAST_STAGE) ? S_IDLE : S_RELEASE;
                    w_nxt_busy  = (r_sr != LAST_STAGE);
                end
                default: begin
                    w_nxt_cnt  = '0;
                    w_nxt_sr   = '0;
                    w_nxt_busy = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_HOLD;
            r_cnt     <= '0;
            r_sr      <= '1;
            r_busy    <= 1'b1;
            r_ack     <= '0;
            r_cause   <= (NUM_SRC + 1)'(1);
            r_req_d   <= '0;
            r_hold_s1 <= 1'b0;
            r_hold_s2 <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_cnt     <= w_nxt_cnt;
            r_sr      <= w_nxt_sr;
            r_busy    <= w_nxt_busy;
            r_ack     <= w_edge;
            r_cause   <= w_nxt_cause;
            r_req_d   <= src_req;
            r_hold_s1 <= hold_ext;
            r_hold_s2 <= r_hold_s1;
        end
    end

    assign src_ack     = r_ack;
    assign stage_reset = r_sr;
    assign busy        = r_busy;
    assign cause       = r_cause;
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Central reset controller that arbitrates reset requests from several sources and drives staged reset outputs for the design's domains. Sources include the power-on path, the CPU soft-reset register, the ESP32 link and the watchdog.
- All domains assert together; each request guarantees a minimum hold time.
- Domains then release in a fixed order: stage 0 first (clock/phi logic), last stage = CPU.
- Records a sticky reset-cause vector for software readback.

Parameters:
NUM_SRC, 4, number of reset request sources
NUM_STAGES, 3, number of staged reset outputs
HOLD_CYCLES, 16, minimum cycles all stages stay asserted (>=1)
STAGE_GAP, 8, cycles between successive stage releases (>=1)

Ports:
sysclk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
src_req  input  NUM_SRC  reset requests, synchronous to sysclk, rising-edge sensitive
src_ack  output  NUM_SRC  one-cycle pulse per accepted request
hold_ext  input  1  asynchronous level; while high, keep all stages in reset
stage_reset  output  NUM_STAGES  active-high reset per domain
busy  output  1  high from reset/request until last stage released
cause  output  NUM_SRC+1  sticky cause; bit0 = power-on, bit i+1 = src_req[i]
cause_clr  input  1  clear cause vector (honoured only when idle)

Behaviour:
- Async reset (reset_n low):
  - state=HOLD, cnt=0, stage_reset=all ones, busy=1.
  - src_ack=0, cause=1 (POR bit only), req edge registers=0, hold_ext sync flops=0.
- hold_ext path: two-flop synchroniser; 2-cycle latency before it affects the FSM.
- Request detection: req_edge[i] = src_req[i] & ~src_req_d[i]. A held-high request is accepted once; the requester must drop it before it can re-request.
- Any req_edge, in any state:
  - src_ack[i]=1 on the next cycle for each edge bit.
  - cause |= {req_edge,1'b0}.
  - All stage_reset=1, state=HOLD, cnt=0.
  - Simultaneous edges are all acked in the same cycle, with no priority.
- HOLD:
  - cnt increments each cycle.
  - hold_ext_sync high forces cnt=0.
  - On the edge where cnt==HOLD_CYCLES-1, hold_ext_sync low and no req_edge: state=RELEASE, cnt=0, stage_reset[0]=0, stage index k=1.
- RELEASE:
  - cnt increments.
  - On cnt==STAGE_GAP-1: stage_reset[k]=0, cnt=0, k=k+1.
  - When the last stage drops: state=IDLE, busy=0 on the same edge.
  - hold_ext_sync high: all stages reassert, state=HOLD, cnt=0.
- IDLE:
  - All stage_reset=0, busy=0.
  - hold_ext_sync high: state=HOLD, all stages reassert, busy=1 (cause unchanged).
- Release timing: stage k drops HOLD_CYCLES + k*STAGE_GAP edges after HOLD entry with cnt=0.
- Stage ordering invariant: stage_reset[k] never deasserts while stage_reset[k-1] is asserted.
- cause_clr:
  - Clears cause to 0 only in IDLE; ignored while busy.
  - Clear coincident with a req_edge: the new bit is set and all other bits are cleared.
- Counter width: clog2(max(HOLD_CYCLES,STAGE_GAP))+1. Counter saturates, never wraps.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Once reset_n is deasserted (synchronised externally), the first sequence runs automatically as the power-on sequence.

Test Plan:
- Power-on, defaults: reset_n rises before edge 0 -> stage_reset=3'b111 until edge 16; then 3'b110 at 16, 3'b100 at 24, 3'b000 at 32; busy falls at 32; cause=5'b00001.
- src_req[2] pulse in IDLE with cause cleared -> src_ack=4'b0100 for exactly 1 cycle; stage_reset=3'b111 next edge; full 32-cycle sequence repeats; cause=5'b01000.
- src_req[0] and src_req[3] rising in same cycle during RELEASE (stage_reset=3'b100) -> both acked together; stages reassert to 3'b111; HOLD restarts at cnt=0; cause |= 5'b10010.
- hold_ext high for 40 cycles mid-HOLD -> stages stay 3'b111 for the whole hold plus 2 sync cycles plus 16 more cycles; no src_ack; cause unchanged.
- cause_clr while busy -> ignored. cause_clr in IDLE -> cause=0. cause_clr coincident with src_req[1] edge -> cause=5'b00100.
- src_req[1] held high 100 cycles -> exactly one ack and one sequence. reset_n pulsed low mid-RELEASE -> immediate 3'b111, cause=5'b00001, busy=1, then full sequence.
